beat_sequencer: RTL
===================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 t  input  4  one-hot beat from the timing generator: 0001=T1, 0010=T2, 0100=T3, 1000=T4; 0000 is legal only before the first T1.
REQ-005 opcode  input  4  instruction opcode, sampled on T1.
REQ-006 halt_req  input  1  request to halt at the next instruction boundary (level or pulse).
REQ-007 resume  input  1  single-cycle pulse to leave HALT.
REQ-008 ir_load, pc_inc, reg_rd, alu_en, mem_rd, mem_wr, pc_load, reg_wr  output  1 each  registered control strobes.
REQ-009 busy  output  1  high while in RUN.
REQ-010 beat_err  output  1  sticky beat-sequence error.
REQ-011 instr_cnt  output  CNT_W  count of retired instructions.

Function
REQ-012 States: IDLE, RUN, HALT, ERR.
REQ-013 All strobes are registered: the strobe for beat Tn is high for exactly the one clk cycle after t==Tn is sampled.
REQ-014 IDLE -> RUN on the first sampled t==0001; that beat produces T1 strobes. t==0000 in IDLE is ignored.
REQ-015 T1 in RUN: ir_load=1, pc_inc=1; latch opcode into op_q.
REQ-016 T2: reg_rd=1.
REQ-017 T3 by op_q: 0x0-0x7 -> alu_en=1; 0x8 -> mem_rd=1; 0x9 -> mem_wr=1; 0xA -> pc_load=1; 0xB-0xF -> no strobe.
REQ-018 T4: reg_wr=1 for op_q 0x0-0x8; instr_cnt increments by 1 for every opcode; wrap FFFF -> 0000 (CNT_W=16).
REQ-019 A halt_req seen high in any RUN cycle sets halt_pend; at T4 with halt_pend set: complete T4 strobes and count, then enter HALT and clear halt_pend.
REQ-020 HALT: all strobes 0, busy=0, t is still tracked for sequence checking; resume sets res_pend, and the next sampled T1 returns to RUN, producing T1 strobes.
REQ-021 resume is ignored outside HALT; halt_req and resume in the same cycle while in HALT: resume wins, and halt_req is captured as a new halt_pend.
REQ-022 Sequence check (active in RUN and HALT): the expected next non-repeat beat is the one-hot rotate-left of the last beat (1000 -> 0001).
REQ-023 Sequence check: a repeat of the same beat is legal and produces no new strobe.
REQ-024 Sequence check: any other value, including 0000, a multi-hot value, or a skipped beat -> ERR.
REQ-025 ERR: beat_err=1 from the next cycle, all strobes 0, busy=0, instr_cnt frozen; ERR is left only by reset.
REQ-026 busy=1 exactly when state==RUN.

Reset
REQ-027 rst low at a clk edge: state=IDLE; all strobes, busy, beat_err, halt_pend, res_pend, op_q=0; instr_cnt=0.
REQ-028 Reset mid-instruction aborts the instruction without counting it; the first cycle after reset drives all outputs 0.

Configuration
REQ-029 Macro BEAT_CHECK_EN defined: REQ-022 to REQ-025 are in force.
REQ-030 BEAT_CHECK_EN undefined: no sequence checking, ERR state absent, beat_err tied 0; strobes are decoded purely from the sampled t value, with a repeated beat still suppressed.

Verification
REQ-031 Reset, t cycles 0000 then 0001, 0010, 0100, 1000 with opcode=0x3 -> one cycle each, lagging t by 1: ir_load+pc_inc, reg_rd, alu_en, reg_wr; instr_cnt=1.
REQ-032 Opcodes 0x8, 0x9, 0xA, 0xF run back-to-back -> at T3: mem_rd, mem_wr, pc_load, none; reg_wr only for 0x8; instr_cnt=4.
REQ-033 halt_req pulsed during T2 -> T4 strobes issued, then busy=0 and no strobes over 8 beats; resume pulse -> strobes restart at the next T1.
REQ-034 With BEAT_CHECK_EN, t goes 0001 then 0100 -> beat_err=1 the next cycle; strobes stay 0 through 2 further instructions; rst low clears beat_err and instr_cnt.
REQ-035 Preload instr_cnt=0xFFFE via repeated instructions or force, then run 2 instructions -> instr_cnt=0x0000.
REQ-036 rst asserted during T3 of an ALU op -> no reg_wr issued, instr_cnt=0, state=IDLE.

Source files
------------

// File: rtl/beat_sequencer.sv
// Beat sequencer: decodes a one-hot T1..T4 beat stream into registered control strobes,
// with halt/resume at instruction boundaries. Define BEAT_CHECK_EN to enable beat-order checking.
module beat_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       t,
  input  logic [3:0]       opcode,
  input  logic             halt_req,
  input  logic             resume,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_rd,
  output logic             alu_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             pc_load,
  output logic             reg_wr,
  output logic             busy,
  output logic             beat_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

`ifdef BEAT_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic [3:0]       op_q, op_d;
  logic             halt_pend_q, halt_pend_d;
  logic             res_pend_q, res_pend_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             ir_load_q, ir_load_d;
  logic             pc_inc_q, pc_inc_d;
  logic             reg_rd_q, reg_rd_d;
  logic             alu_en_q, alu_en_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             pc_load_q, pc_load_d;
  logic             reg_wr_q, reg_wr_d;
  logic             new_beat;
  logic             fire_t1;
  logic             fire_run;
`ifdef BEAT_CHECK_EN
  logic             beat_err_q, beat_err_d;
  logic [3:0]       next_beat;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    halt_pend_d = halt_pend_q;
    res_pend_d  = res_pend_q;
    instr_cnt_d = instr_cnt_q;
    ir_load_d   = 1'b0;
    pc_inc_d    = 1'b0;
    reg_rd_d    = 1'b0;
    alu_en_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    pc_load_d   = 1'b0;
    reg_wr_d    = 1'b0;
    fire_t1     = 1'b0;
    fire_run    = 1'b0;
    // A beat equal to the last one seen is a repeat and never re-fires its strobes.
    new_beat    = (t != last_q);
`ifdef BEAT_CHECK_EN
    beat_err_d  = beat_err_q;
    next_beat   = {last_q[2:0], last_q[3]};
`endif

    case (state_q)
      S_IDLE: begin
        if (t == T1) begin
          state_d = S_RUN;
          last_d  = t;
          fire_t1 = 1'b1;
        end
      end
      S_RUN: begin
        last_d = t;
        if (halt_req) halt_pend_d = 1'b1;
`ifdef BEAT_CHECK_EN
        if (new_beat && (t != next_beat)) begin
          state_d    = S_ERR;
          beat_err_d = 1'b1;
        end else
`endif
        if (new_beat) fire_run = 1'b1;
      end
      S_HALT: begin
        last_d = t;
        if (resume) begin
          res_pend_d = 1'b1;
          if (halt_req) halt_pend_d = 1'b1;
        end
`ifdef BEAT_CHECK_EN
        if (new_beat && (t != next_beat)) begin
          state_d    = S_ERR;
          beat_err_d = 1'b1;
        end else
`endif
        if (new_beat && (t == T1) && (res_pend_q || resume)) begin
          state_d    = S_RUN;
          res_pend_d = 1'b0;
          fire_t1    = 1'b1;
        end
      end
`ifdef BEAT_CHECK_EN
      S_ERR: ;
`endif
      default: state_d = S_IDLE;
    endcase

    if (fire_run) begin
      case (t)
        T1: fire_t1 = 1'b1;
        T2: reg_rd_d = 1'b1;
        T3: begin
          if (op_q <= 4'h7) alu_en_d = 1'b1;
          else begin
            case (op_q)
              4'h8:    mem_rd_d  = 1'b1;
              4'h9:    mem_wr_d  = 1'b1;
              4'hA:    pc_load_d = 1'b1;
              default: ;
            endcase
          end
        end
        T4: begin
          reg_wr_d    = (op_q <= 4'h8);
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
          // A halt request arriving on the T4 cycle itself still halts at this boundary.
          if (halt_pend_q || halt_req) begin
            state_d     = S_HALT;
            halt_pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (fire_t1) begin
      ir_load_d = 1'b1;
      pc_inc_d  = 1'b1;
      op_d      = opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_q      <= '0;
      op_q        <= '0;
      halt_pend_q <= 1'b0;
      res_pend_q  <= 1'b0;
      instr_cnt_q <= '0;
      ir_load_q   <= 1'b0;
      pc_inc_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
`ifdef BEAT_CHECK_EN
      beat_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      halt_pend_q <= halt_pend_d;
      res_pend_q  <= res_pend_d;
      instr_cnt_q <= instr_cnt_d;
      ir_load_q   <= ir_load_d;
      pc_inc_q    <= pc_inc_d;
      reg_rd_q    <= reg_rd_d;
      alu_en_q    <= alu_en_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      pc_load_q   <= pc_load_d;
      reg_wr_q    <= reg_wr_d;
`ifdef BEAT_CHECK_EN
      beat_err_q  <= beat_err_d;
`endif
    end
  end

  assign ir_load   = ir_load_q;
  assign pc_inc    = pc_inc_q;
  assign reg_rd    = reg_rd_q;
  assign alu_en    = alu_en_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign pc_load   = pc_load_q;
  assign reg_wr    = reg_wr_q;
  assign busy      = (state_q == S_RUN);
  assign instr_cnt = instr_cnt_q;
`ifdef BEAT_CHECK_EN
  assign beat_err  = beat_err_q;
`else
  assign beat_err  = 1'b0;
`endif

endmodule
